// File: rtl/picomips_core_if.sv
// Program ROM bus between picomips_core and its combinational program ROM.
//
// Signals:
//   instr_addr  PC_W bits      fetch address, driven by the core (= pc)
//   instr_data  ARG_W+3 bits   instruction word, driven combinationally by the ROM
//
// Modports:
//   master  core side (drives instr_addr, samples instr_data)
//   slave   ROM side  (samples instr_addr, drives instr_data)
interface picomips_core_if #(
  parameter int unsigned ARG_W = 5,
  parameter int unsigned PC_W  = 6
);
  logic [PC_W-1:0]  instr_addr;
  logic [ARG_W+2:0] instr_data;

  modport master (output instr_addr, input instr_data);
  modport slave  (input instr_addr, output instr_data);
endinterface

// File: rtl/picomips_core.sv
// picomips_core: multi-cycle accumulator processor (FETCH -> DECODE -> EXEC -> WB).
//
// Ports:
//   Clock     system clock, rising edge
//   nReset    asynchronous active-low reset
//   sw_data   switch data operand loaded by LSW
//   sw_go     asynchronous handshake switch, two-flop synchronised internally
//   rom       program ROM bus (picomips_core_if.master): instr_addr out, instr_data in
//   acc_out   accumulator value (drives LEDs)
//   waiting   high while stalled in HEI
//
// Build option:
//   PICOMIPS_SAT_EN  when defined, ADD/ADDI/MULI saturate instead of wrapping.
//
// Instruction word: {opcode[2:0], arg[ARG_W-1:0]}.
//   000 JMP  001 LSW  010 RTA  011 ATR  100 ADD  101 ADDI  110 MULI  111 HEI
module picomips_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ARG_W  = 5,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned PC_W   = 6
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_go,
  picomips_core_if.master   rom,
  output logic [DATA_W-1:0] acc_out,
  output logic              waiting
);

  localparam int unsigned InstrW = ARG_W + 3;
  localparam int unsigned IdxW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned ProdW  = 2 * DATA_W;

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StWb} state_e;
  typedef enum logic [2:0] {
    OpJmp, OpLsw, OpRta, OpAtr, OpAdd, OpAddi, OpMuli, OpHei
  } op_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] opnd_q;
  logic [InstrW-1:0] ir_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              go_meta_q;
  logic              go_s_q;
  logic              waiting_q;

  // Decode of the registered instruction
  op_e               op;
  logic [ARG_W-1:0]  arg;
  logic [IdxW-1:0]   idx;
  logic [DATA_W-1:0] arg_sext;
  logic [DATA_W-1:0] imm;

  assign op       = op_e'(ir_q[InstrW-1:ARG_W]);
  assign arg      = ir_q[ARG_W-1:0];
  assign idx      = arg[IdxW-1:0];
  assign arg_sext = DATA_W'($signed(arg));
  assign imm      = arg_sext << 1;

  // Arithmetic datapath
  logic [DATA_W-1:0]       addend;
  logic [DATA_W:0]         sum;
  logic signed [ProdW-1:0] prod;
  logic [DATA_W-1:0]       add_res;
  logic [DATA_W-1:0]       mul_res;
  logic                    unused_bits;

  assign addend = (op == OpAdd) ? opnd_q : imm;
  assign sum    = {acc_q[DATA_W-1], acc_q} + {addend[DATA_W-1], addend};
  assign prod   = ProdW'($signed(acc_q)) * ProdW'($signed(imm));

`ifdef PICOMIPS_SAT_EN
  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ProdW-DATA_W-3:0] mul_hi;
  logic                    add_ovf;
  logic                    mul_ovf;

  // Sum overflows when the extra sign bit disagrees with the result sign bit.
  assign add_ovf = sum[DATA_W] ^ sum[DATA_W-1];
  // Product slice is valid only if everything above it sign-extends its top bit.
  assign mul_hi  = prod[ProdW-1:DATA_W+2];
  assign mul_ovf = !((&mul_hi) || !(|mul_hi));
  assign add_res = add_ovf ? (sum[DATA_W] ? SatMin : SatMax) : sum[DATA_W-1:0];
  assign mul_res = mul_ovf ? (prod[ProdW-1] ? SatMin : SatMax) : prod[DATA_W+2:3];
  assign unused_bits = ^prod[2:0];
`else
  assign add_res = sum[DATA_W-1:0];
  assign mul_res = prod[DATA_W+2:3];
  assign unused_bits = ^{prod[2:0], prod[ProdW-1:DATA_W+3], sum[DATA_W]};
`endif

  logic [DATA_W-1:0] acc_exec;
  logic              hei_stall;
  logic [PC_W-1:0]   pc_next;

  always_comb begin
    acc_exec = acc_q;
    case (op)
      OpLsw:         acc_exec = sw_data;
      OpRta:         acc_exec = opnd_q;
      OpAdd, OpAddi: acc_exec = add_res;
      OpMuli:        acc_exec = mul_res;
      default:       acc_exec = acc_q;
    endcase
  end

  // HEI 0 waits for go=1, HEI 1 waits for go=0.
  assign hei_stall = (op == OpHei) && (go_s_q == arg[0]);
  // JMP target is the zero-extended (or truncated) argument.
  assign pc_next   = (op == OpJmp) ? PC_W'(arg) : pc_q + PC_W'(1);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      ir_q      <= '0;
      go_meta_q <= 1'b0;
      go_s_q    <= 1'b0;
      waiting_q <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      go_meta_q <= sw_go;
      go_s_q    <= go_meta_q;
      case (state_q)
        StFetch: begin
          ir_q    <= rom.instr_data;
          state_q <= StDecode;
        end
        StDecode: begin
          opnd_q  <= regs_q[idx];
          state_q <= StExec;
        end
        StExec: begin
          if (hei_stall) begin
            waiting_q <= 1'b1;
          end else begin
            waiting_q <= 1'b0;
            acc_q     <= acc_exec;
            state_q   <= StWb;
          end
        end
        StWb: begin
          if (op == OpAtr) begin
            regs_q[idx] <= acc_q;
          end
          pc_q    <= pc_next;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign rom.instr_addr = pc_q;
  assign acc_out        = acc_q;
  assign waiting        = waiting_q;

endmodule

// File: tb/tb_picomips_core.sv
// Bench for picomips_core (default parameters: DATA_W=8, ARG_W=5, NREGS=4, PC_W=6).
// An instruction-level reference model advances on the same clock and is compared
// against acc_out, instr_addr and waiting on every falling edge; directed programs
// add literal expectations. Build with PICOMIPS_SAT_EN to check the saturating variant.
module tb_picomips_core;

  logic       Clock;
  logic       nReset;
  logic [7:0] sw_data;
  logic       sw_go;
  logic [7:0] acc_out;
  logic       waiting;

  logic [7:0] rom_mem [64];

  picomips_core_if #(.ARG_W(5), .PC_W(6)) bus ();
  assign bus.instr_data = rom_mem[bus.instr_addr];

  picomips_core #(
    .DATA_W (8),
    .ARG_W  (5),
    .NREGS  (4),
    .PC_W   (6)
  ) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .sw_data (sw_data),
    .sw_go   (sw_go),
    .rom     (bus),
    .acc_out (acc_out),
    .waiting (waiting)
  );

`ifdef PICOMIPS_SAT_EN
  localparam logic [7:0] ExpOvfPos = 8'h7F;
  localparam logic [7:0] ExpOvfNeg = 8'h80;
`else
  localparam logic [7:0] ExpOvfPos = 8'h90;
  localparam logic [7:0] ExpOvfNeg = 8'h6C;
`endif

  int checks   = 0;
  int failures = 0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_regs [4];
  logic [5:0] m_pc;
  logic [7:0] m_acc;
  logic       m_wait;
  logic [1:0] m_go;     // sw_go delayed by one and two clocks
  int         m_k;      // cycles already spent in the current instruction
  int         m_retired;
  logic [7:0] m_ins;

  function automatic logic [7:0] exec_acc(input logic [7:0] ins, input logic [7:0] acc,
                                          input logic [7:0] r, input logic [7:0] sw);
    int a;
    int imm;
    int v;
    a   = int'($signed(acc));
    imm = int'($signed(ins[4:0])) * 2;
    case (ins[7:5])
      3'd1:    return sw;
      3'd2:    return r;
      3'd4:    v = a + int'($signed(r));
      3'd5:    v = a + imm;
      3'd6:    v = (a * imm) >>> 3;
      default: return acc;
    endcase
`ifdef PICOMIPS_SAT_EN
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return 8'(v);
  endfunction

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_pc      = '0;
      m_acc     = '0;
      m_wait    = 1'b0;
      m_go      = '0;
      m_k       = 0;
      m_retired = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
    end else begin
      m_ins = rom_mem[m_pc];
      if (m_k == 2) begin
        if (m_ins[7:5] == 3'd7 && m_go[1] == m_ins[0]) begin
          m_wait = 1'b1;
        end else begin
          m_wait = 1'b0;
          m_acc  = exec_acc(m_ins, m_acc, m_regs[m_ins[1:0]], sw_data);
          m_k    = 3;
        end
      end else if (m_k == 3) begin
        if (m_ins[7:5] == 3'd3) m_regs[m_ins[1:0]] = m_acc;
        m_pc = (m_ins[7:5] == 3'd0) ? 6'(m_ins[4:0]) : m_pc + 6'd1;
        m_k  = 0;
        m_retired++;
      end else begin
        m_k++;
      end
      m_go = {m_go[0], sw_go};
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge Clock) begin
    check("cyc_instr_addr", 32'(bus.instr_addr), 32'(m_pc));
    check("cyc_acc_out", 32'(acc_out), 32'(m_acc));
    check("cyc_waiting", 32'(waiting), 32'(m_wait));
  end

  // ---------------- helpers ----------------
  task automatic reset_fill();
    @(posedge Clock);
    #2 nReset = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'hA0;  // ADDI 0
  endtask

  task automatic release_reset();
    @(posedge Clock);
    #2 nReset = 1'b1;
  endtask

  task automatic wait_retired(input int n);
    int budget;
    budget = 2000;
    while (m_retired < n && budget > 0) begin
      @(negedge Clock);
      budget--;
    end
    if (m_retired < n) begin
      checks++;
      failures++;
      $display("FAIL wait_retired: got %0d retired expected %0d", m_retired, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nReset  = 1'b1;
    sw_data = '0;
    sw_go   = 1'b0;
    #1 nReset = 1'b0;

    // Reset with random inputs, then release into program P1
    reset_fill();
    rom_mem[0] = 8'h20;  // LSW
    rom_mem[1] = 8'hC3;  // MULI 3
    rom_mem[2] = 8'h05;  // JMP 5
    rom_mem[3] = 8'h21;  // skipped
    rom_mem[4] = 8'hA1;  // skipped
    rom_mem[5] = 8'h20;  // LSW
    rom_mem[6] = 8'hDE;  // MULI 30 (-2)
    rom_mem[7] = 8'h07;  // JMP 7
    repeat (5) begin
      @(posedge Clock);
      #2 sw_data = 8'($urandom);
      sw_go = 1'($urandom);
    end
    @(negedge Clock);
    check("reset_acc", 32'(acc_out), 32'h00);
    check("reset_addr", 32'(bus.instr_addr), 32'h0);
    check("reset_waiting", 32'(waiting), 32'h0);
    sw_data = 8'h40;
    sw_go   = 1'b0;
    release_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      check("addr_after_release", 32'(bus.instr_addr), (k < 4) ? 32'h0 : 32'h1);
    end
    wait_retired(1); check("p1_lsw", 32'(acc_out), 32'h40);
    wait_retired(2); check("p1_muli3", 32'(acc_out), 32'h30);
    wait_retired(3); check("p1_jmp5", 32'(bus.instr_addr), 32'h5);
    wait_retired(6); check("p1_muli_neg2", 32'(acc_out), 32'hE0);
    wait_retired(9); check("p1_jmp_self", 32'(bus.instr_addr), 32'h7);

    // P2: arithmetic overflow
    reset_fill();
    rom_mem[0] = 8'h20;  // LSW
    rom_mem[1] = 8'hAA;  // ADDI 10 (+20)
    rom_mem[2] = 8'h20;  // LSW
    rom_mem[3] = 8'hB6;  // ADDI 22 (-20)
    rom_mem[4] = 8'h04;  // JMP 4
    sw_data = 8'h7C;
    release_reset();
    wait_retired(2); check("p2_ovf_pos", 32'(acc_out), 32'(ExpOvfPos));
    sw_data = 8'h80;
    wait_retired(4); check("p2_ovf_neg", 32'(acc_out), 32'(ExpOvfNeg));

    // P3: register file, aliasing, reset during HEI stall
    reset_fill();
    rom_mem[0] = 8'h20;  // LSW
    rom_mem[1] = 8'h62;  // ATR 2
    rom_mem[2] = 8'h20;  // LSW
    rom_mem[3] = 8'h82;  // ADD 2
    rom_mem[4] = 8'h20;  // LSW
    rom_mem[5] = 8'h66;  // ATR 6 (aliases reg 2)
    rom_mem[6] = 8'hA1;  // ADDI 1
    rom_mem[7] = 8'h42;  // RTA 2
    rom_mem[8] = 8'hE0;  // HEI 0
    sw_data = 8'h11;
    sw_go   = 1'b0;
    release_reset();
    wait_retired(2); sw_data = 8'h05;
    wait_retired(4); check("p3_add_reg", 32'(acc_out), 32'h16);
    sw_data = 8'h03;
    wait_retired(7); check("p3_addi", 32'(acc_out), 32'h05);
    wait_retired(8); check("p3_rta_alias", 32'(acc_out), 32'h03);
    repeat (20) @(negedge Clock);
    check("p3_hei_waiting", 32'(waiting), 32'h1);
    check("p3_hei_addr", 32'(bus.instr_addr), 32'h8);
    #2 nReset = 1'b0;
    #1;
    check("p3_abort_addr", 32'(bus.instr_addr), 32'h0);
    check("p3_abort_acc", 32'(acc_out), 32'h0);
    check("p3_abort_waiting", 32'(waiting), 32'h0);
    reset_fill();
    rom_mem[0] = 8'hA1;  // ADDI 1
    rom_mem[1] = 8'h42;  // RTA 2
    rom_mem[2] = 8'h02;  // JMP 2
    release_reset();
    wait_retired(1); check("p3_post_addi", 32'(acc_out), 32'h02);
    wait_retired(2); check("p3_reg_cleared", 32'(acc_out), 32'h00);

    // P4: HEI handshake timing
    reset_fill();
    rom_mem[0] = 8'hE0;  // HEI 0
    rom_mem[1] = 8'hE1;  // HEI 1
    rom_mem[2] = 8'hA3;  // ADDI 3
    rom_mem[3] = 8'h03;  // JMP 3
    sw_go = 1'b0;
    release_reset();
    repeat (20) @(negedge Clock);
    check("p4_hei0_waiting", 32'(waiting), 32'h1);
    check("p4_hei0_addr", 32'(bus.instr_addr), 32'h0);
    @(posedge Clock);
    #2 sw_go = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check("p4_hei0_release", 32'(waiting), (k < 3) ? 32'h1 : 32'h0);
    end
    @(negedge Clock);
    check("p4_hei0_advance", 32'(bus.instr_addr), 32'h1);
    repeat (20) @(negedge Clock);
    check("p4_hei1_waiting", 32'(waiting), 32'h1);
    check("p4_hei1_addr", 32'(bus.instr_addr), 32'h1);
    @(posedge Clock);
    #2 sw_go = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check("p4_hei1_release", 32'(waiting), (k < 3) ? 32'h1 : 32'h0);
    end
    @(negedge Clock);
    check("p4_hei1_advance", 32'(bus.instr_addr), 32'h2);
    wait_retired(3); check("p4_addi", 32'(acc_out), 32'h06);

    // P5: pc wrap from 63 to 0
    reset_fill();
    rom_mem[0]  = 8'h1F;  // JMP 31
    rom_mem[63] = 8'hA1;  // ADDI 1
    release_reset();
    wait_retired(33); check("p5_addr63", 32'(bus.instr_addr), 32'h3F);
    wait_retired(34); check("p5_wrap", 32'(bus.instr_addr), 32'h0);
    check("p5_acc", 32'(acc_out), 32'h02);

    // Random program and inputs, with one asynchronous reset mid-run
    reset_fill();
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'($urandom);
    release_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge Clock);
      #2 sw_data = 8'($urandom);
      if ($urandom_range(0, 5) == 0) sw_go = ~sw_go;
      if (c == 2000) begin
        nReset = 1'b0;
        #2 nReset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
